// File: rtl/cache_line_controller_if.sv
// Request, SRAM and cache-array signals of the line controller.
// slave = the controller, master = everything around it.
interface cache_line_controller_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 2
);
  logic [ADDR_W-1:0]                address;
  logic [DATA_W-1:0]                write_data;
  logic                             mem_r_en;
  logic                             mem_w_en;
  logic [DATA_W-1:0]                rdata;
  logic                             ready;
  logic [ADDR_W-1:0]                sram_address;
  logic [DATA_W-1:0]                sram_write_data;
  logic                             sram_write_en;
  logic                             sram_read_en;
  logic [DATA_W-1:0]                sram_read_data;
  logic                             sram_ready;
  logic [ADDR_W-3:0]                cache_address;
  logic                             cache_read_en;
  logic [DATA_W-1:0]                cache_read_data;
  logic                             cache_hit;
  logic                             cache_write_en;
  logic [DATA_W*WORDS_PER_LINE-1:0] cache_line_data;
  logic                             cache_word_write_en;
  logic [DATA_W-1:0]                cache_word_data;
  logic                             cache_invalidate;

  modport slave (
    input  address, write_data, mem_r_en, mem_w_en,
           sram_read_data, sram_ready, cache_read_data, cache_hit,
    output rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en,
           cache_address, cache_read_en, cache_write_en, cache_line_data,
           cache_word_write_en, cache_word_data, cache_invalidate
  );

  modport master (
    output address, write_data, mem_r_en, mem_w_en,
           sram_read_data, sram_ready, cache_read_data, cache_hit,
    input  rdata, ready, sram_address, sram_write_data, sram_write_en, sram_read_en,
           cache_address, cache_read_en, cache_write_en, cache_line_data,
           cache_word_write_en, cache_word_data, cache_invalidate
  );
endinterface

// File: rtl/cache_line_controller.sv
// Read-allocate, write-through cache controller: N-word line fill by beat counter,
// selectable write-hit policy and saturating hit/miss counters.
module cache_line_controller #(
  parameter int                ADDR_W           = 32,
  parameter int                DATA_W           = 32,
  parameter int                WORDS_PER_LINE   = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR        = 1024,
  parameter bit                WRITE_HIT_UPDATE = 1'b0,
  parameter int                CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_line_controller_if.slave bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int LB = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL, LINE_WRITE, SRAM_WRITE} state_t;

  state_t                                 state, state_nxt;
  logic [LB-1:0]                          beat;
  logic                                   refill;
  logic                                   wr_first;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]  line_buf;
  logic [ADDR_W-1:0]                      offs_addr;
  logic                                   unused_offs;

  assign offs_addr           = bus.address - BASE_ADDR;
  assign bus.cache_address   = offs_addr[ADDR_W-1:2];
  assign unused_offs         = ^offs_addr[1:0];
  assign bus.cache_word_data = bus.write_data;
  assign bus.cache_line_data = line_buf;

  always_comb begin
    state_nxt               = state;
    bus.ready               = 1'b0;
    bus.rdata               = '0;
    bus.sram_address        = '0;
    bus.sram_write_data     = '0;
    bus.sram_write_en       = 1'b0;
    bus.sram_read_en        = 1'b0;
    bus.cache_read_en       = 1'b0;
    bus.cache_write_en      = 1'b0;
    bus.cache_word_write_en = 1'b0;
    bus.cache_invalidate    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_r_en)      state_nxt = LOOKUP;
        else if (bus.mem_w_en) state_nxt = SRAM_WRITE;
        else                   bus.ready = 1'b1;
      end
      LOOKUP: begin
        bus.cache_read_en = 1'b1;
        if (bus.cache_hit) begin
          state_nxt = IDLE;
          bus.ready = 1'b1;
          bus.rdata = bus.cache_read_data;
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        // Line-aligned, ascending beats
        bus.sram_read_en = 1'b1;
        bus.sram_address = {bus.address[ADDR_W-1:LB+2], beat, 2'b00};
        if (bus.sram_ready && (&beat)) state_nxt = LINE_WRITE;
      end
      LINE_WRITE: begin
        bus.cache_write_en = 1'b1;
        state_nxt          = LOOKUP;
      end
      SRAM_WRITE: begin
        bus.sram_write_en       = 1'b1;
        bus.sram_address        = bus.address;
        bus.sram_write_data     = bus.write_data;
        bus.cache_invalidate    = wr_first && !WRITE_HIT_UPDATE;
        bus.cache_word_write_en = wr_first && WRITE_HIT_UPDATE;
        if (bus.sram_ready) begin
          state_nxt = IDLE;
          bus.ready = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      refill     <= 1'b0;
      wr_first   <= 1'b0;
      line_buf   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state    <= state_nxt;
      wr_first <= (state == IDLE) && !bus.mem_r_en && bus.mem_w_en;
      case (state)
        LOOKUP: begin
          // The lookup after a fill is the same request; its hit is not a new hit
          beat   <= '0;
          refill <= 1'b0;
          if (bus.cache_hit && !refill && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          if (!bus.cache_hit && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
        FILL: if (bus.sram_ready) begin
          line_buf[beat] <= bus.sram_read_data;
          beat           <= beat + LB'(1);
        end
        LINE_WRITE: refill <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_line_controller.sv
// Bench for cache_line_controller: cache-array and SRAM stubs around two instances,
// transaction-level reference model (memory image, cached-line set, counters).
module tb_cache_line_controller;
  localparam logic [31:0] BASE = 32'h400;
  localparam logic [31:0] SEED = 32'h1234_5678;
  localparam logic [31:0] K1   = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // dut0: 4-word line, invalidate on write, 16-bit counters
  cache_line_controller_if #(.WORDS_PER_LINE(4)) b0 ();
  logic [15:0] hc0, mc0;
  cache_line_controller #(.WORDS_PER_LINE(4), .BASE_ADDR(BASE), .WRITE_HIT_UPDATE(1'b0), .CNT_W(16))
    dut0 (.clk(clk), .rst(rst), .bus(b0), .hit_count(hc0), .miss_count(mc0));

  // dut1: 2-word line, update on write, 2-bit counters
  cache_line_controller_if #(.WORDS_PER_LINE(2)) b1 ();
  logic [1:0] hc1, mc1;
  cache_line_controller #(.WORDS_PER_LINE(2), .BASE_ADDR(BASE), .WRITE_HIT_UPDATE(1'b1), .CNT_W(2))
    dut1 (.clk(clk), .rst(rst), .bus(b1), .hit_count(hc1), .miss_count(mc1));

  function automatic logic [31:0] init_word(input logic [9:0] w);
    return ({22'h0, w} * 32'h9E37_79B9) ^ SEED;
  endfunction

  // ---------------- dut0 environment ----------------
  logic [63:0]      cv0 = '0;
  logic [3:0][31:0] cd0 [64];
  wire  [5:0]       ci0 = b0.cache_address[7:2];
  assign b0.cache_hit       = cv0[ci0];
  assign b0.cache_read_data = cd0[ci0][b0.cache_address[1:0]];
  always @(posedge clk) begin
    if (b0.cache_write_en) begin cv0[ci0] <= 1'b1; cd0[ci0] <= b0.cache_line_data; end
    if (b0.cache_invalidate) cv0[ci0] <= 1'b0;
    if (b0.cache_word_write_en && cv0[ci0]) cd0[ci0][b0.cache_address[1:0]] <= b0.cache_word_data;
  end

  int            k0 = 2;
  int            sc0 = 0;
  logic          spur0 = 1'b0;
  bit            spur_en = 1'b0;
  logic [31:0]   smem0 [1024];
  logic [1023:0] swr0 = '0;
  wire           req0 = b0.sram_read_en | b0.sram_write_en;
  wire  [9:0]    sa0  = b0.sram_address[11:2];
  assign b0.sram_ready     = (req0 && sc0 == k0 - 1) || (spur0 && !req0);
  assign b0.sram_read_data = b0.sram_read_en ? (swr0[sa0] ? smem0[sa0] : init_word(sa0)) : 32'h0;
  always @(posedge clk) begin
    if (!req0 || b0.sram_ready) sc0 <= 0; else sc0 <= sc0 + 1;
    if (b0.sram_write_en && b0.sram_ready) begin smem0[sa0] <= b0.sram_write_data; swr0[sa0] <= 1'b1; end
  end
  always @(negedge clk) spur0 <= spur_en && ($urandom_range(0, 1) == 1);

  int          nf0 = 0, ncw0 = 0, nsw0 = 0, ninv0 = 0, nww0 = 0;
  logic [31:0] fa0 [256];
  logic [31:0] wa0 = '0, wd0 = '0;
  always @(posedge clk) begin
    if (b0.sram_read_en && b0.sram_ready) begin fa0[nf0 % 256] <= b0.sram_address; nf0 <= nf0 + 1; end
    if (b0.cache_write_en) ncw0 <= ncw0 + 1;
    if (b0.sram_write_en) nsw0 <= nsw0 + 1;
    if (b0.sram_write_en && b0.sram_ready) begin wa0 <= b0.sram_address; wd0 <= b0.sram_write_data; end
    if (b0.cache_invalidate) ninv0 <= ninv0 + 1;
    if (b0.cache_word_write_en) nww0 <= nww0 + 1;
  end

  // ---------------- dut1 environment (SRAM answers every cycle) ----------------
  logic [63:0]      cv1 = '0;
  logic [1:0][31:0] cd1 [64];
  wire  [5:0]       ci1 = b1.cache_address[6:1];
  assign b1.cache_hit       = cv1[ci1];
  assign b1.cache_read_data = cd1[ci1][b1.cache_address[0]];
  always @(posedge clk) begin
    if (b1.cache_write_en) begin cv1[ci1] <= 1'b1; cd1[ci1] <= b1.cache_line_data; end
    if (b1.cache_invalidate) cv1[ci1] <= 1'b0;
    if (b1.cache_word_write_en && cv1[ci1]) cd1[ci1][b1.cache_address[0]] <= b1.cache_word_data;
  end
  assign b1.sram_ready     = b1.sram_read_en | b1.sram_write_en;
  assign b1.sram_read_data = b1.sram_read_en ? (b1.sram_address ^ K1) : 32'h0;

  int          nww1 = 0, ninv1 = 0;
  logic [31:0] wwd1 = '0;
  always @(posedge clk) begin
    if (b1.cache_word_write_en) begin nww1 <= nww1 + 1; wwd1 <= b1.cache_word_data; end
    if (b1.cache_invalidate) ninv1 <= ninv1 + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] g0 [int];
  bit          gc0 [64];
  int          hit0 = 0, miss0 = 0;
  logic [31:0] g1 [int];
  bit          gc1 [64];
  int          hit1 = 0, miss1 = 0;

  function automatic logic [31:0] gword0(input logic [31:0] a);
    return g0.exists(int'(a[11:2])) ? g0[int'(a[11:2])] : init_word(a[11:2]);
  endfunction

  task automatic read0(input logic [31:0] addr, input bit both);
    int cyc, nf_s, cw_s, sw_s, line;
    bit hexp;
    logic [31:0] exp, got, lb;
    line = int'((addr - BASE) >> 4); hexp = gc0[line]; exp = gword0(addr); lb = {addr[31:4], 4'h0};
    nf_s = nf0; cw_s = ncw0; sw_s = nsw0;
    @(negedge clk);
    b0.address = addr; b0.mem_r_en = 1'b1; b0.mem_w_en = both; b0.write_data = $urandom;
    for (cyc = 1; cyc <= 200; cyc++) begin #1; if (b0.ready) break; @(negedge clk); end
    got = b0.rdata;
    @(negedge clk); b0.mem_r_en = 1'b0; b0.mem_w_en = 1'b0; #1;
    if (hexp) hit0++; else begin miss0++; gc0[line] = 1'b1; end
    nchk++; if (cyc > 200) begin nerr++; $display("FAIL rd0_timeout addr=%h", addr); end
    nchk++; if (got !== exp) begin nerr++; $display("FAIL rd0_data addr=%h got=%h want=%h", addr, got, exp); end
    nchk++; if (cyc !== (hexp ? 2 : 4 + 4 * k0)) begin nerr++; $display("FAIL rd0_latency addr=%h got=%0d want=%0d", addr, cyc, hexp ? 2 : 4 + 4 * k0); end
    nchk++; if (hc0 !== 16'(hit0)) begin nerr++; $display("FAIL rd0_hit_count got=%0d want=%0d", hc0, hit0); end
    nchk++; if (mc0 !== 16'(miss0)) begin nerr++; $display("FAIL rd0_miss_count got=%0d want=%0d", mc0, miss0); end
    nchk++; if (ncw0 - cw_s !== (hexp ? 0 : 1)) begin nerr++; $display("FAIL rd0_line_writes got=%0d want=%0d", ncw0 - cw_s, hexp ? 0 : 1); end
    nchk++; if (nf0 - nf_s !== (hexp ? 0 : 4)) begin nerr++; $display("FAIL rd0_beats got=%0d want=%0d", nf0 - nf_s, hexp ? 0 : 4); end
    if (!hexp && nf0 - nf_s == 4)
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (fa0[(nf_s + i) % 256] !== lb + 32'(4 * i)) begin
          nerr++; $display("FAIL rd0_beat_addr beat=%0d got=%h want=%h", i, fa0[(nf_s + i) % 256], lb + 32'(4 * i));
        end
      end
    if (both) begin
      nchk++; if (nsw0 !== sw_s) begin nerr++; $display("FAIL rd0_both_sram_write cycles=%0d want=0", nsw0 - sw_s); end
    end
  endtask

  task automatic write0(input logic [31:0] addr, input logic [31:0] wd);
    int cyc, inv_s, ww_s, sw_s;
    inv_s = ninv0; ww_s = nww0; sw_s = nsw0;
    @(negedge clk);
    b0.address = addr; b0.mem_r_en = 1'b0; b0.mem_w_en = 1'b1; b0.write_data = wd;
    for (cyc = 1; cyc <= 200; cyc++) begin #1; if (b0.ready) break; @(negedge clk); end
    @(negedge clk); b0.mem_w_en = 1'b0; #1;
    g0[int'(addr[11:2])] = wd; gc0[int'((addr - BASE) >> 4)] = 1'b0;
    nchk++; if (cyc !== 1 + k0) begin nerr++; $display("FAIL wr0_latency got=%0d want=%0d", cyc, 1 + k0); end
    nchk++; if (ninv0 - inv_s !== 1) begin nerr++; $display("FAIL wr0_invalidate got=%0d want=1", ninv0 - inv_s); end
    nchk++; if (nww0 !== ww_s) begin nerr++; $display("FAIL wr0_word_write got=%0d want=0", nww0 - ww_s); end
    nchk++; if (nsw0 - sw_s !== k0) begin nerr++; $display("FAIL wr0_sram_we_cycles got=%0d want=%0d", nsw0 - sw_s, k0); end
    nchk++; if (wa0 !== addr || wd0 !== wd) begin nerr++; $display("FAIL wr0_sram_req got=%h/%h want=%h/%h", wa0, wd0, addr, wd); end
    nchk++; if (hc0 !== 16'(hit0) || mc0 !== 16'(miss0)) begin nerr++; $display("FAIL wr0_counters got=%0d/%0d want=%0d/%0d", hc0, mc0, hit0, miss0); end
  endtask

  task automatic rd1(input logic [31:0] addr);
    int cyc, line;
    bit hexp;
    logic [31:0] exp, got;
    line = int'((addr - BASE) >> 3); hexp = gc1[line];
    exp = g1.exists(int'(addr[11:2])) ? g1[int'(addr[11:2])] : (addr ^ K1);
    @(negedge clk); b1.address = addr; b1.mem_r_en = 1'b1;
    for (cyc = 1; cyc <= 100; cyc++) begin #1; if (b1.ready) break; @(negedge clk); end
    got = b1.rdata;
    @(negedge clk); b1.mem_r_en = 1'b0; #1;
    if (hexp) hit1 = (hit1 < 3) ? hit1 + 1 : 3; else begin miss1 = (miss1 < 3) ? miss1 + 1 : 3; gc1[line] = 1'b1; end
    nchk++; if (got !== exp) begin nerr++; $display("FAIL rd1_data addr=%h got=%h want=%h", addr, got, exp); end
    nchk++; if (cyc !== (hexp ? 2 : 6)) begin nerr++; $display("FAIL rd1_latency got=%0d want=%0d", cyc, hexp ? 2 : 6); end
    nchk++; if (hc1 !== 2'(hit1) || mc1 !== 2'(miss1)) begin nerr++; $display("FAIL rd1_counters got=%0d/%0d want=%0d/%0d", hc1, mc1, hit1, miss1); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    b0.address = BASE; b0.write_data = '0; b0.mem_r_en = 1'b0; b0.mem_w_en = 1'b0;
    b1.address = BASE; b1.write_data = '0; b1.mem_r_en = 1'b0; b1.mem_w_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nchk++; if (b0.ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got=%b want=1", b0.ready); end
    nchk++;
    if ({b0.rdata, b0.sram_address, b0.sram_write_data, b0.sram_write_en, b0.sram_read_en, b0.cache_address,
         b0.cache_read_en, b0.cache_write_en, b0.cache_line_data, b0.cache_word_write_en, b0.cache_word_data,
         b0.cache_invalidate, hc0, mc0} !== '0) begin
      nerr++; $display("FAIL reset_outputs got=nonzero want=0 (sram_addr=%h line=%h)", b0.sram_address, b0.cache_line_data);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cold_fill_and_hit();
    k0 = 2;
    read0(BASE, 1'b0);
    read0(BASE + 32'h8, 1'b0);
  endtask

  task automatic test_write_invalidate();
    k0 = 2;
    write0(BASE + 32'h4, 32'hDEAD_BEEF);
    read0(BASE + 32'h4, 1'b0);
  endtask

  task automatic test_read_write_together();
    read0(BASE + 32'hC, 1'b1);
    read0(BASE + 32'h34, 1'b1);
  endtask

  task automatic test_reset_mid_fill();
    int nf_s, cw_s;
    logic [31:0] addr;
    addr = BASE + 32'hC4; k0 = 2;
    nf_s = nf0; cw_s = ncw0;
    @(negedge clk); b0.address = addr; b0.mem_r_en = 1'b1;
    for (int c = 0; c < 100 && (nf0 - nf_s) < 2; c++) @(negedge clk);
    nchk++; if (nf0 - nf_s !== 2) begin nerr++; $display("FAIL rst_fill_reach_beat2 got=%0d want=2", nf0 - nf_s); end
    b0.mem_r_en = 1'b0; rst = 1'b0; #1;
    nchk++; if (b0.ready !== 1'b1) begin nerr++; $display("FAIL rst_fill_ready got=%b want=1", b0.ready); end
    nchk++;
    if ({b0.rdata, b0.sram_address, b0.sram_write_data, b0.sram_write_en, b0.sram_read_en, b0.cache_read_en,
         b0.cache_write_en, b0.cache_line_data, b0.cache_word_write_en, b0.cache_invalidate, hc0, mc0} !== '0) begin
      nerr++; $display("FAIL rst_fill_outputs got=nonzero want=0 (sram_addr=%h mc=%0d)", b0.sram_address, mc0);
    end
    @(negedge clk); rst = 1'b1;
    hit0 = 0; miss0 = 0;
    repeat (2) @(negedge clk);
    nchk++; if (ncw0 !== cw_s) begin nerr++; $display("FAIL rst_fill_line_write got=%0d want=0", ncw0 - cw_s); end
    read0(addr, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int op;
    spur_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      addr = BASE + ($urandom_range(0, 7) << 4) + ($urandom_range(0, 3) << 2);
      k0 = $urandom_range(1, 3);
      op = $urandom_range(0, 9);
      if (op < 6) read0(addr, 1'b0);
      else if (op < 9) write0(addr, $urandom);
      else read0(addr, 1'b1);
    end
    spur_en = 1'b0;
  endtask

  task automatic test_write_update();
    int cyc, ww_s, inv_s;
    rd1(BASE + 32'h10);
    rd1(BASE + 32'h14);
    ww_s = nww1; inv_s = ninv1;
    @(negedge clk); b1.address = BASE + 32'h14; b1.write_data = 32'hDEAD_BEEF; b1.mem_w_en = 1'b1;
    for (cyc = 1; cyc <= 100; cyc++) begin #1; if (b1.ready) break; @(negedge clk); end
    @(negedge clk); b1.mem_w_en = 1'b0; #1;
    g1[int'(b1.address[11:2])] = 32'hDEAD_BEEF;
    nchk++; if (cyc !== 2) begin nerr++; $display("FAIL wr1_latency got=%0d want=2", cyc); end
    nchk++; if (nww1 - ww_s !== 1) begin nerr++; $display("FAIL wr1_word_write got=%0d want=1", nww1 - ww_s); end
    nchk++; if (wwd1 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL wr1_word_data got=%h want=deadbeef", wwd1); end
    nchk++; if (ninv1 !== inv_s) begin nerr++; $display("FAIL wr1_invalidate got=%0d want=0", ninv1 - inv_s); end
    rd1(BASE + 32'h14);
  endtask

  task automatic test_counter_saturation();
    for (int i = 0; i < 5; i++) rd1(BASE + 32'h10);
    rd1(BASE + 32'h20);
    rd1(BASE + 32'h30);
    rd1(BASE + 32'h40);
  endtask

  initial begin
    test_reset();
    test_cold_fill_and_hit();
    test_write_invalidate();
    test_read_write_together();
    test_reset_mid_fill();
    test_random();
    test_write_update();
    test_counter_saturation();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
